// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a small sizing helper.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single-bit level crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages clear to 0 so a held-high input is re-qualified after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, holds downstream reset a little
// longer, then releases it; re-asserts reset on any lock loss.
//
//   state     | meaning
//   WAIT_LOCK | rst_out asserted, waiting for synchronised lock
//   STABILIZE | lock seen, counting STABLE_CYCLES of continuous lock
//   HOLD      | lock stable, holding rst_out for HOLD_CYCLES more
//   RUN       | rst_out released, ready high
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES) + 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("reset_sequencer: STABLE_CYCLES out of range 1..65535");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range 1..65535");
  end

  logic                  lock_s;
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LOSS_CNT_W-1:0] loss_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state logic; one counter serves both the STABILIZE and HOLD phases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_nxt  = loss_count;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABILIZE;
          cnt_nxt   = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          if (loss_count != '1) begin
            loss_nxt = loss_count + LOSS_CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      loss_count <= '0;
      rst_out    <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      loss_count <= loss_nxt;
      rst_out    <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=2.
module tb_reset_sequencer;

  localparam int S = 8;
  localparam int H = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         pll_locked;
  logic         rst_out;
  logic         ready;
  logic [W-1:0] loss_count;
  logic [1:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  reset_sequencer #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .LOSS_CNT_W    (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .rst_out    (rst_out),
    .ready      (ready),
    .loss_count (loss_count),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural model: the state is a function of how many consecutive edges the
  // synchronised lock has been seen high (n). 0 -> waiting, 1..S -> stabilising,
  // S+1..S+H -> holding, beyond -> running.
  int m_n     = 0;
  int m_loss  = 0;
  int m_state = 0;
  bit m_p1    = 1'b0;
  bit m_p2    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_n = 0; m_loss = 0; m_valid = 1'b1;
    end else begin
      if (m_p2) begin
        if (m_n < S + H + 1) m_n = m_n + 1;
      end else begin
        if (m_n > S + H && m_loss < (1 << W) - 1) m_loss = m_loss + 1;
        m_n = 0;
      end
      m_p2 = m_p1;
      m_p1 = pll_locked;
    end
    if (m_n == 0)          m_state = 0;
    else if (m_n <= S)     m_state = 1;
    else if (m_n <= S + H) m_state = 2;
    else                   m_state = 3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("model_state",  32'(state_dbg),  32'(m_state));
      chk("model_rst",    32'(rst_out),    32'(m_state != 3));
      chk("model_ready",  32'(ready),      32'(m_state == 3));
      chk("model_loss",   32'(loss_count), 32'(m_loss));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge-0 sample of pll_locked high is arranged (input
  // already high on the next edge). Checks the literal release timeline.
  task automatic seq_check(input string tag);
    tick();
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 1)  chk({tag, "_e1_state"},  32'(state_dbg), 32'd0);
      if (e == 2)  chk({tag, "_e2_state"},  32'(state_dbg), 32'd1);
      if (e == 9)  chk({tag, "_e9_state"},  32'(state_dbg), 32'd1);
      if (e == 10) chk({tag, "_e10_state"}, 32'(state_dbg), 32'd2);
      if (e == 13) chk({tag, "_e13_rst"},   32'(rst_out),   32'd1);
      if (e == 14) begin
        chk({tag, "_e14_rst"},   32'(rst_out),   32'd0);
        chk({tag, "_e14_ready"}, 32'(ready),     32'd1);
        chk({tag, "_e14_state"}, 32'(state_dbg), 32'd3);
        chk({tag, "_e14_model"}, 32'(m_state),   32'd3);
      end
    end
  endtask

  int loss_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (3) tick();
    chk("rst_state",  32'(state_dbg),  32'd0);
    chk("rst_rstout", 32'(rst_out),    32'd1);
    chk("rst_ready",  32'(ready),      32'd0);
    chk("rst_loss",   32'(loss_count), 32'd0);
    chk("rst_model",  32'(m_n),        32'd0);

    // Release with lock held high throughout reset.
    @(negedge clk) reset = 1'b0;
    seq_check("rel");

    // Five lock losses from RUN; loss counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) pll_locked = 1'b0;
      tick();
      tick();
      chk("loss_k1_rst", 32'(rst_out), 32'd0);
      tick();
      chk("loss_k2_rst",   32'(rst_out),    32'd1);
      chk("loss_k2_ready", 32'(ready),      32'd0);
      chk("loss_count",    32'(loss_count), 32'(loss_exp[i]));
      @(negedge clk) pll_locked = 1'b1;
      repeat (16) tick();
      chk("loss_rerun", 32'(state_dbg), 32'd3);
    end

    // One-cycle reset pulse in RUN with lock held high.
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rpulse_rst",   32'(rst_out),    32'd1);
    chk("rpulse_ready", 32'(ready),      32'd0);
    chk("rpulse_loss",  32'(loss_count), 32'd0);
    chk("rpulse_state", 32'(state_dbg),  32'd0);
    @(negedge clk) reset = 1'b0;
    seq_check("rpulse");

    // One-cycle lock glitch during STABILIZE restarts the sequence.
    @(negedge clk) begin reset = 1'b1; pll_locked = 1'b0; end
    tick(); tick();
    @(negedge clk) reset = 1'b0;
    repeat (5) tick();
    chk("glitch_idle", 32'(state_dbg), 32'd0);
    @(negedge clk) pll_locked = 1'b1;
    repeat (6) tick();
    chk("glitch_pre_state", 32'(state_dbg), 32'd1);
    @(negedge clk) pll_locked = 1'b0;
    tick();
    @(negedge clk) pll_locked = 1'b1;
    seq_check("glitch");
    chk("glitch_loss", 32'(loss_count), 32'd0);

    // Lock drop during HOLD: back to WAIT_LOCK, no loss counted.
    @(negedge clk) reset = 1'b1;
    tick();
    @(negedge clk) reset = 1'b0;
    tick();
    repeat (11) tick();
    chk("hold_state", 32'(state_dbg), 32'd2);
    @(negedge clk) pll_locked = 1'b0;
    tick();
    @(negedge clk) pll_locked = 1'b1;
    tick();
    tick();
    chk("hold_drop_state", 32'(state_dbg),  32'd0);
    chk("hold_drop_rst",   32'(rst_out),    32'd1);
    chk("hold_drop_loss",  32'(loss_count), 32'd0);
    repeat (20) tick();
    chk("hold_recover", 32'(state_dbg), 32'd3);

    // Lock never high: stays in WAIT_LOCK with reset asserted.
    @(negedge clk) begin reset = 1'b1; pll_locked = 1'b0; end
    tick();
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (rst_out !== 1'b1 || state_dbg !== 2'd0) begin
        chk("nolock_rst",   32'(rst_out),   32'd1);
        chk("nolock_state", 32'(state_dbg), 32'd0);
      end
    end
    chk("nolock_final_rst",   32'(rst_out),   32'd1);
    chk("nolock_final_state", 32'(state_dbg), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: cycles pll_locked must stay high before the hold phase starts; the legal range is 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 16: extra cycles rst_out is held after stabilisation; the legal range is 1..65535.
REQ-003 Parameter LOSS_CNT_W, default 8: width of the lock-loss counter.
REQ-004 clk  input  1  sole clock; the block SHALL use no other clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL LOCKED flag, asynchronous to clk.
REQ-007 rst_out  output  1  registered, synchronous, active-high reset for downstream logic in the clk domain.
REQ-008 ready  output  1  registered; high only in RUN.
REQ-009 loss_count  output  LOSS_CNT_W  saturating count of lock losses seen in RUN.
REQ-010 state_dbg  output  2  current FSM state encoding for debug.

Function
REQ-011 pll_locked SHALL pass through a two-flop synchroniser; only the second flop output (lock_s) SHALL be used by the FSM.
REQ-012 The FSM SHALL have the states WAIT_LOCK=0, STABILIZE=1, HOLD=2 and RUN=3.
REQ-013 WAIT_LOCK: if lock_s=1, the FSM SHALL go to STABILIZE and clear the counter.
REQ-014 STABILIZE: while lock_s=1, the counter SHALL increment.
REQ-015 STABILIZE: if lock_s=1 and the counter equals STABLE_CYCLES-1, the FSM SHALL go to HOLD and clear the counter.
REQ-016 STABILIZE: if lock_s=0 in any cycle, the FSM SHALL go to WAIT_LOCK with no loss_count change.
REQ-017 HOLD: the counter SHALL increment, and at HOLD_CYCLES-1 the FSM SHALL go to RUN.
REQ-018 HOLD: if lock_s=0, the FSM SHALL go to WAIT_LOCK with no loss_count change.
REQ-019 RUN: if lock_s=0, the FSM SHALL go to WAIT_LOCK and loss_count SHALL increment by 1.
REQ-020 loss_count SHALL saturate at 2^LOSS_CNT_W-1 and SHALL never wrap.
REQ-021 rst_out and ready SHALL update on the same edge as the state register.
REQ-022 rst_out=0 and ready=1 SHALL hold exactly when the registered state is RUN.
REQ-023 Latency: if pll_locked is first sampled high at edge 0 and stays high, rst_out SHALL fall at edge 2+STABLE_CYCLES+HOLD_CYCLES.
REQ-024 Lock-loss latency: if pll_locked is first sampled low in RUN at edge k, rst_out SHALL rise at edge k+2.
REQ-025 The single counter SHALL be $clog2 of max(STABLE_CYCLES,HOLD_CYCLES)+1 bits wide and SHALL be shared by STABILIZE and HOLD.
REQ-026 A lock_s pulse shorter than the remaining STABILIZE/HOLD time SHALL restart the full sequence from WAIT_LOCK.
REQ-027 rst_out SHALL never be low while the state is not RUN, including the cycle of any transition out of RUN.

Reset
REQ-028 Under reset=1, the outputs SHALL take: state WAIT_LOCK, counter 0, both synchroniser flops 0, rst_out=1, ready=0, loss_count=0, state_dbg=0.
REQ-029 reset asserted mid-sequence or in RUN SHALL take effect at the next edge and SHALL override every FSM transition in that cycle.
REQ-030 After reset is released, the sequence SHALL restart under REQ-023 timing even if pll_locked stayed high throughout.

Structure
REQ-031 Package reset_sequencer_pkg SHALL hold the state enum type and the state encodings.
REQ-032 Sub-module sync_2ff SHALL implement the two-flop synchroniser with reset value 0, instantiated once.
REQ-033 Elaboration SHALL fail via an assertion if STABLE_CYCLES<1 or HOLD_CYCLES<1.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=2)
REQ-034 Reset release with pll_locked high from edge 0: rst_out falls and ready rises at edge 14; state_dbg reads 1, 2, 3 at edges 2, 10, 14.
REQ-035 pll_locked low for one cycle during STABILIZE: the FSM returns to WAIT_LOCK, the count restarts, rst_out falls 14 edges after the re-sample high, and loss_count stays 0.
REQ-036 In RUN, pll_locked dropped at edge k: rst_out=1 and ready=0 at edge k+2, loss_count=1.
REQ-037 Five lock losses from RUN: loss_count reads 1, 2, 3, 3, 3.
REQ-038 reset pulsed for one cycle while in RUN with pll_locked high: rst_out=1 the next edge, loss_count=0, and RUN is re-entered 14 edges after reset is released.
REQ-039 pll_locked never high: rst_out stays 1 and state_dbg stays 0 for 1000 cycles.
